// File: rtl/shift_pkg.sv
// Shared definitions for the bounce/rotate one-hot shifter: mode encodings
// and the helper that sizes the position index.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROTL   = 2'b01,
        MODE_ROTR   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // Width of an index into a WIDTH-bit one-hot vector (at least 1 bit).
    function automatic int pos_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Step prescaler: issues one tick every div+1 enabled cycles. A count that
// already exceeds a freshly lowered div ticks on the next enabled cycle.
module tick_div #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    assign tick = en && (r_cnt >= div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/bounce_shifter.sv
// One-hot position shifter that bounces between the ends or rotates either
// way, stepping at a prescaled rate, with a synchronous position load.
module bounce_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [DIV_W-1:0]           div,
    input  logic                       load,
    input  logic [$clog2(WIDTH)-1:0]   load_pos,
    output logic [WIDTH-1:0]           count,
    output logic [$clog2(WIDTH)-1:0]   pos,
    output logic                       dir,
    output logic                       end_hit
);

    localparam int            PW   = pos_w(WIDTH);
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_pos;
    logic             r_dir;
    logic             r_end_hit;

    mode_e            w_mode;
    logic             w_run;
    logic             w_tick;
    logic [PW-1:0]    w_load_pos;
    logic             w_up;
    logic [PW-1:0]    w_bounce_pos;
    logic [PW-1:0]    w_pos_nxt;
    logic             w_dir_nxt;
    logic             w_move;
    logic             w_end;

    assign w_mode = mode_e'(mode);
    assign w_run  = en && (w_mode != MODE_HOLD);

    tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_run),
        .clr     (load),
        .div     (div),
        .tick    (w_tick)
    );

    assign w_load_pos = (load_pos > LAST) ? LAST : load_pos;

    // Sitting on an end with dir pointing outward turns the step inward.
    assign w_up         = r_dir ? (r_pos != LAST) : (r_pos == '0);
    assign w_bounce_pos = w_up ? (r_pos + PW'(1)) : (r_pos - PW'(1));

    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        w_move    = 1'b0;
        if (load) begin
            w_move    = 1'b1;
            w_pos_nxt = w_load_pos;
            if (w_mode == MODE_BOUNCE) begin
                if (w_load_pos == LAST) begin
                    w_dir_nxt = 1'b0;
                end else if (w_load_pos == '0) begin
                    w_dir_nxt = 1'b1;
                end
            end
        end else if (w_tick) begin
            w_move = 1'b1;
            case (w_mode)
                MODE_BOUNCE: begin
                    w_pos_nxt = w_bounce_pos;
                    if (w_bounce_pos == LAST) begin
                        w_dir_nxt = 1'b0;
                    end else if (w_bounce_pos == '0) begin
                        w_dir_nxt = 1'b1;
                    end else begin
                        w_dir_nxt = w_up;
                    end
                end
                MODE_ROTL: begin
                    w_pos_nxt = (r_pos == LAST) ? '0 : (r_pos + PW'(1));
                    w_dir_nxt = 1'b1;
                end
                MODE_ROTR: begin
                    w_pos_nxt = (r_pos == '0) ? LAST : (r_pos - PW'(1));
                    w_dir_nxt = 1'b0;
                end
                default: begin
                    w_move = 1'b0;
                end
            endcase
        end
    end

    assign w_end = w_move && ((w_pos_nxt == '0) || (w_pos_nxt == LAST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos     <= '0;
            r_dir     <= 1'b1;
            r_count   <= WIDTH'(1);
            r_end_hit <= 1'b0;
        end else begin
            r_pos     <= w_pos_nxt;
            r_dir     <= w_dir_nxt;
            r_count   <= WIDTH'(1) << w_pos_nxt;
            r_end_hit <= w_end;
        end
    end

    assign count   = r_count;
    assign pos     = r_pos;
    assign dir     = r_dir;
    assign end_hit = r_end_hit;

endmodule

// File: tb/tb_bounce_shifter.sv
// Directed self-checking bench for bounce_shifter (WIDTH=8, DIV_W=4).
module tb_bounce_shifter;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] div;
    logic       load;
    logic [2:0] load_pos;
    logic [7:0] count;
    logic [2:0] pos;
    logic       dir;
    logic       end_hit;

    int n_checks = 0;
    int n_fail   = 0;

    bounce_shifter #(
        .WIDTH (8),
        .DIV_W (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .mode     (mode),
        .div      (div),
        .load     (load),
        .load_pos (load_pos),
        .count    (count),
        .pos      (pos),
        .dir      (dir),
        .end_hit  (end_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] c, input logic d, input logic e);
        n_checks++;
        if (count !== c || dir !== d || end_hit !== e) begin
            n_fail++;
            $display("FAIL %s: count=%h dir=%b end_hit=%b, expected count=%h dir=%b end_hit=%b",
                     name, count, dir, end_hit, c, d, e);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; mode = 2'b00; div = 4'd0; load = 1'b0; load_pos = 3'd0;
        #12;
        n_checks++;
        if (pos !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_pos: pos=%0d expected 0", pos);
        end
        chk("reset_state", 8'h01, 1'b1, 1'b0);
        #5 reset_n = 1'b1;
        edge1();
        chk("idle_after_reset", 8'h01, 1'b1, 1'b0);
    endtask

    task automatic test_bounce();
        logic [7:0] exp_c [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        logic       exp_d [14] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        logic       exp_e [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        en = 1'b1; mode = 2'b00; div = 4'd0;
        for (int i = 0; i < 14; i++) begin
            edge1();
            chk($sformatf("bounce_%0d", i), exp_c[i], exp_d[i], exp_e[i]);
        end
    endtask

    task automatic test_rotl();
        int p;
        mode = 2'b01; div = 4'd3;
        for (int s = 1; s <= 8; s++) begin
            for (int k = 1; k <= 4; k++) begin
                edge1();
                p = (k == 4) ? (s % 8) : (s - 1);
                chk($sformatf("rotl_s%0d_k%0d", s, k), 8'(1 << p), 1'b1,
                    (k == 4) && (p == 0 || p == 7));
            end
        end
    endtask

    task automatic test_rotr();
        mode = 2'b10; div = 4'd0;
        edge1();
        chk("rotr_wrap", 8'h80, 1'b0, 1'b1);
        edge1();
        chk("rotr_next", 8'h40, 1'b0, 1'b0);
    endtask

    task automatic test_load();
        mode = 2'b00; div = 4'd2;
        edge1();
        chk("load_pre1", 8'h40, 1'b0, 1'b0);
        edge1();
        chk("load_pre2", 8'h40, 1'b0, 1'b0);
        load = 1'b1; load_pos = 3'd7;
        edge1();
        chk("load_over_step", 8'h80, 1'b0, 1'b1);
        load = 1'b0;
        edge1();
        chk("load_wait1", 8'h80, 1'b0, 1'b0);
        edge1();
        chk("load_wait2", 8'h80, 1'b0, 1'b0);
        edge1();
        chk("load_then_step", 8'h40, 1'b0, 1'b0);
        mode = 2'b01; load = 1'b1; load_pos = 3'd0;
        edge1();
        chk("load_rot_dir_kept", 8'h01, 1'b0, 1'b1);
        mode = 2'b00;
        edge1();
        chk("load_bounce_zero", 8'h01, 1'b1, 1'b1);
        load = 1'b0;
    endtask

    task automatic test_freeze();
        div = 4'd3; mode = 2'b00;
        edge1();
        chk("frz_pre1", 8'h01, 1'b1, 1'b0);
        edge1();
        chk("frz_pre2", 8'h01, 1'b1, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge1();
            chk($sformatf("frz_en_%0d", i), 8'h01, 1'b1, 1'b0);
        end
        en = 1'b1;
        edge1();
        chk("frz_resume1", 8'h01, 1'b1, 1'b0);
        edge1();
        chk("frz_resume_step", 8'h02, 1'b1, 1'b0);
        edge1();
        chk("hold_pre", 8'h02, 1'b1, 1'b0);
        mode = 2'b11;
        for (int i = 0; i < 5; i++) begin
            edge1();
            chk($sformatf("hold_%0d", i), 8'h02, 1'b1, 1'b0);
        end
        mode = 2'b00;
        edge1();
        chk("hold_resume1", 8'h02, 1'b1, 1'b0);
        edge1();
        chk("hold_resume2", 8'h02, 1'b1, 1'b0);
        edge1();
        chk("hold_resume_step", 8'h04, 1'b1, 1'b0);
    endtask

    task automatic test_lower_div();
        div = 4'd5;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk($sformatf("lowdiv_pre_%0d", i), 8'h04, 1'b1, 1'b0);
        end
        div = 4'd1;
        edge1();
        chk("lowdiv_immediate", 8'h08, 1'b1, 1'b0);
        edge1();
        chk("lowdiv_wait", 8'h08, 1'b1, 1'b0);
        edge1();
        chk("lowdiv_step", 8'h10, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_pos = 3'd5;
        edge1();
        chk("ar_setup", 8'h20, 1'b1, 1'b0);
        load = 1'b0; en = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if (pos !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset_pos: pos=%0d expected 0", pos);
        end
        chk("async_reset", 8'h01, 1'b1, 1'b0);
        #2 reset_n = 1'b1;
        div = 4'd2; mode = 2'b00; en = 1'b1;
        edge1();
        chk("post_reset1", 8'h01, 1'b1, 1'b0);
        edge1();
        chk("post_reset2", 8'h01, 1'b1, 1'b0);
        edge1();
        chk("post_reset_step", 8'h02, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_rotl();
        test_rotr();
        test_load();
        test_freeze();
        test_lower_div();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
